// File: rtl/ahblite_pkg.sv
// Shared AHB-Lite encodings and the matrix address-to-slot decode.
package ahblite_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic       HRESP_OKAY    = 1'b0;
  localparam logic       HRESP_ERROR   = 1'b1;

  localparam int SLOT_MSB  = 31;
  localparam int SLOT_LSB  = 28;
  localparam int NUM_SLOTS = 16;

  // Slot is the top address nibble; boot remap swaps slots 0 and 1.
  function automatic logic [3:0] decode_slot(input logic [31:0] addr, input logic remap);
    logic [3:0] slot;
    slot = 4'(addr >> SLOT_LSB);
    if (remap && slot[3:1] == 3'b000) slot[0] = ~slot[0];
    return slot;
  endfunction

endpackage

// File: rtl/ahblite_default_slave.sv
// Internal responder for unmapped transfers: a two-cycle AHB ERROR.
module ahblite_default_slave
  import ahblite_pkg::*;
(
  input  logic HCLK,
  input  logic HRESETN,
  input  logic load,
  output logic def_ready,
  output logic def_resp
);

  typedef enum logic [1:0] {DIDLE, DERR1, DERR2} dstate_e;
  dstate_e state;

  // NOTE: sequential state uses non-blocking assignments so every flop updates from pre-edge values.
  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) begin
      state     <= DIDLE;
      def_ready <= 1'b1;
      def_resp  <= HRESP_OKAY;
    end else begin
      unique case (state)
        DIDLE: if (load) begin
          state     <= DERR1;
          def_ready <= 1'b0;
          def_resp  <= HRESP_ERROR;
        end
        DERR1: begin
          state     <= DERR2;
          def_ready <= 1'b1;
          def_resp  <= HRESP_ERROR;
        end
        default: if (load) begin
          state     <= DERR1;
          def_ready <= 1'b0;
          def_resp  <= HRESP_ERROR;
        end else begin
          state     <= DIDLE;
          def_ready <= 1'b1;
          def_resp  <= HRESP_OKAY;
        end
      endcase
    end
  end

endmodule

// File: rtl/ahblite_master_stage.sv
// Per-master AHB-Lite matrix front end: slot decode, address/data phase tracking, response mux.
// Defining MASTER_STAGE_REMAP_EN adds the REMAP input (boot remap swaps decode slots 0 and 1).
module ahblite_master_stage
  import ahblite_pkg::*;
#(
  parameter int          DATA_W   = 32,
  parameter logic [15:0] SLAVE_EN = 16'hFFFF
) (
  input  logic                          HCLK,
  input  logic                          HRESETN,
  input  logic [31:0]                   HADDR,
  input  logic [1:0]                    HTRANS,
  input  logic [2:0]                    HBURST,
  input  logic                          HMASTLOCK,
`ifdef MASTER_STAGE_REMAP_EN
  input  logic                          REMAP,
`endif
  output logic                          HREADY,
  output logic                          HRESP,
  output logic [DATA_W-1:0]             HRDATA,
  output logic [NUM_SLOTS-1:0]          SADDRSEL,
  input  logic [NUM_SLOTS-1:0]          SADDRACC,
  output logic                          GATEDHMASTLOCK,
  output logic                          GATEDBURSTXFER,
  input  logic [NUM_SLOTS-1:0]          SHREADY,
  input  logic [NUM_SLOTS-1:0]          SHRESP,
  input  logic [NUM_SLOTS*DATA_W-1:0]   SHRDATA
);

  typedef enum logic [1:0] {AIDLE, AREQ, ATAKEN} astate_e;
  astate_e astate;

  logic              remap, active, mapped, taken;
  logic              addr_acc, data_done, load, load_def;
  logic [3:0]        slot, p_slot, d_slot, load_slot;
  logic              d_valid, d_def, def_ready, def_resp;
  logic              lock_held, burst_flag, burst_start;
  logic [DATA_W-1:0] slv_rdata [NUM_SLOTS];

`ifdef MASTER_STAGE_REMAP_EN
  assign remap = REMAP;
`else
  assign remap = 1'b0;
`endif

  for (genvar k = 0; k < NUM_SLOTS; k++) begin : g_rdata
    assign slv_rdata[k] = SHRDATA[k*DATA_W +: DATA_W];
  end

  assign active    = HTRANS[1];
  assign slot      = decode_slot(HADDR, remap);
  assign mapped    = SLAVE_EN[slot];
  assign taken     = (astate == ATAKEN);
  assign data_done = !d_valid || (d_def ? def_ready : SHREADY[d_slot]);

  // An unmapped transfer is owned by the default slave, which accepts as soon as the data bus frees.
  assign addr_acc  = active && !taken && (mapped ? SADDRACC[slot] : data_done);
  assign load      = data_done && (taken || addr_acc);
  assign load_def  = !taken && !mapped;
  assign load_slot = taken ? p_slot : slot;

  assign SADDRSEL  = (active && mapped && !taken) ? (16'h0001 << slot) : '0;
  assign HREADY    = data_done && (!active || addr_acc || taken);
  assign HRESP     = d_valid ? (d_def ? def_resp : SHRESP[d_slot]) : HRESP_OKAY;
  assign HRDATA    = (d_valid && !d_def) ? slv_rdata[d_slot] : '0;

  assign burst_start    = (HTRANS == HTRANS_NONSEQ) && (HBURST != HBURST_SINGLE);
  assign GATEDHMASTLOCK = HMASTLOCK && (active || lock_held);
  assign GATEDBURSTXFER = burst_flag || burst_start;

  ahblite_default_slave u_default_slave (
    .HCLK      (HCLK),
    .HRESETN   (HRESETN),
    .load      (load && load_def),
    .def_ready (def_ready),
    .def_resp  (def_resp)
  );

  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) begin
      astate <= AIDLE;
      p_slot <= '0;
    end else begin
      unique case (astate)
        AIDLE, AREQ: begin
          // Slave took the address while the previous data phase is still running.
          if (active && mapped && SADDRACC[slot] && !data_done) begin
            astate <= ATAKEN;
            p_slot <= slot;
          end else if (active && !addr_acc) begin
            astate <= AREQ;
          end else begin
            astate <= AIDLE;
          end
        end
        ATAKEN:  if (data_done) astate <= AIDLE;
        default: astate <= AIDLE;
      endcase
    end
  end

  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) begin
      d_valid <= 1'b0;
      d_slot  <= '0;
      d_def   <= 1'b0;
    end else if (data_done) begin
      d_valid <= load;
      d_slot  <= load_slot;
      d_def   <= load && load_def;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) begin
      lock_held  <= 1'b0;
      burst_flag <= 1'b0;
    end else if (HREADY) begin
      if (HMASTLOCK && active) lock_held <= 1'b1;
      else if (!HMASTLOCK)     lock_held <= 1'b0;
      if (HTRANS == HTRANS_IDLE)        burst_flag <= 1'b0;
      else if (HTRANS == HTRANS_NONSEQ) burst_flag <= burst_start;
    end else if (HRESP == HRESP_ERROR) begin
      burst_flag <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ahblite_master_stage.sv
// Directed bench for ahblite_master_stage with a transaction-level reference model.
`timescale 1ns/1ps
module tb_ahblite_master_stage;

  localparam int          DW     = 32;
  localparam logic [15:0] SLV_EN = 16'h7FFF;
  localparam logic [15:0] ALL    = 16'hFFFF;
  localparam logic [15:0] NONE   = 16'h0000;
  localparam logic [1:0]  T_IDLE = 2'b00, T_NSEQ = 2'b10, T_SEQ = 2'b11;
  localparam logic [2:0]  B_SINGLE = 3'b000, B_INCR4 = 3'b011;

  logic            HCLK = 1'b0;
  logic            HRESETN;
  logic [31:0]     HADDR;
  logic [1:0]      HTRANS;
  logic [2:0]      HBURST;
  logic            HMASTLOCK;
`ifdef MASTER_STAGE_REMAP_EN
  logic            REMAP = 1'b0;
`endif
  logic            HREADY, HRESP;
  logic [DW-1:0]   HRDATA;
  logic [15:0]     SADDRSEL, SADDRACC, SHREADY, SHRESP;
  logic            GATEDHMASTLOCK, GATEDBURSTXFER;
  logic [16*DW-1:0] SHRDATA;
  logic [DW-1:0]   slv_data [16];

  int total = 0;
  int bad   = 0;

  always #5 HCLK = ~HCLK;

  for (genvar k = 0; k < 16; k++) begin : g_pack
    assign SHRDATA[k*DW +: DW] = slv_data[k];
  end

  ahblite_master_stage #(.DATA_W(DW), .SLAVE_EN(SLV_EN)) dut (
    .HCLK           (HCLK),
    .HRESETN        (HRESETN),
    .HADDR          (HADDR),
    .HTRANS         (HTRANS),
    .HBURST         (HBURST),
    .HMASTLOCK      (HMASTLOCK),
`ifdef MASTER_STAGE_REMAP_EN
    .REMAP          (REMAP),
`endif
    .HREADY         (HREADY),
    .HRESP          (HRESP),
    .HRDATA         (HRDATA),
    .SADDRSEL       (SADDRSEL),
    .SADDRACC       (SADDRACC),
    .GATEDHMASTLOCK (GATEDHMASTLOCK),
    .GATEDBURSTXFER (GATEDBURSTXFER),
    .SHREADY        (SHREADY),
    .SHRESP         (SHRESP),
    .SHRDATA        (SHRDATA)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the transfer owning the data bus, an address already handed to a slave, lock/burst flags.
  bit         own_v, own_def, tk_v, m_lock, m_burst;
  logic [3:0] own_slot, tk_slot;
  int         own_err;

  typedef struct packed {
    logic        hready;
    logic        hresp;
    logic [31:0] hrdata;
    logic [15:0] sel;
    logic        glock;
    logic        gburst;
  } exp_t;

  task automatic model_clear();
    own_v = 0; own_def = 0; own_slot = 0; own_err = 0;
    tk_v = 0; tk_slot = 0; m_lock = 0; m_burst = 0;
  endtask

  function automatic logic [3:0] tb_slot();
    logic [3:0] s;
    s = HADDR[31:28];
`ifdef MASTER_STAGE_REMAP_EN
    if (REMAP && s < 4'd2) s = 4'd1 - s;
`endif
    return s;
  endfunction

  function automatic bit m_done();
    if (!own_v) return 1'b1;
    if (own_def) return own_err == 2;
    return SHREADY[own_slot];
  endfunction

  function automatic exp_t m_expect();
    exp_t       e;
    logic [3:0] s;
    bit         act, mp, ok;
    s   = tb_slot();
    act = HTRANS[1];
    mp  = SLV_EN[s];
    ok  = tk_v || !act || (mp ? SADDRACC[s] : m_done());
    e.sel    = (act && mp && !tk_v) ? (16'h1 << s) : 16'h0;
    e.hready = m_done() && ok;
    e.hresp  = own_v && (own_def || SHRESP[own_slot]);
    e.hrdata = (own_v && !own_def) ? slv_data[own_slot] : 32'h0;
    e.glock  = HMASTLOCK && (act || m_lock);
    e.gburst = m_burst || (HTRANS == T_NSEQ && HBURST != B_SINGLE);
    return e;
  endfunction

  task automatic model_step();
    exp_t       e;
    logic [3:0] s;
    bit         act, mp, d;
    if (!HRESETN) begin
      model_clear();
      return;
    end
    e   = m_expect();
    d   = m_done();
    s   = tb_slot();
    act = HTRANS[1];
    mp  = SLV_EN[s];
    if (e.hready) begin
      if (HMASTLOCK && act) m_lock = 1;
      else if (!HMASTLOCK)  m_lock = 0;
      if (HTRANS == T_IDLE)      m_burst = 0;
      else if (HTRANS == T_NSEQ) m_burst = (HBURST != B_SINGLE);
    end else if (e.hresp) begin
      m_burst = 0;
    end
    if (d) begin
      if (tk_v) begin
        own_v = 1; own_slot = tk_slot; own_def = 0; tk_v = 0;
      end else if (act && (!mp || SADDRACC[s])) begin
        own_v = 1; own_slot = s; own_def = !mp;
      end else begin
        own_v = 0;
      end
      own_err = 1;
    end else begin
      if (own_def) own_err = 2;
      if (!tk_v && act && mp && SADDRACC[s]) begin
        tk_v = 1; tk_slot = s;
      end
    end
  endtask

  // Every cycle: DUT outputs against the model.
  initial begin
    exp_t e;
    forever begin
      @(negedge HCLK);
      e = m_expect();
      check("HREADY", {31'b0, HREADY}, {31'b0, e.hready});
      check("HRESP", {31'b0, HRESP}, {31'b0, e.hresp});
      check("HRDATA", HRDATA, e.hrdata);
      check("SADDRSEL", {16'b0, SADDRSEL}, {16'b0, e.sel});
      check("GATEDHMASTLOCK", {31'b0, GATEDHMASTLOCK}, {31'b0, e.glock});
      check("GATEDBURSTXFER", {31'b0, GATEDBURSTXFER}, {31'b0, e.gburst});
    end
  end

  task automatic cyc(input logic [1:0] tr, input logic [31:0] a, input logic [2:0] hb,
                     input logic lk, input logic [15:0] acc, input logic [15:0] rdy,
                     input logic [15:0] rsp);
    @(posedge HCLK);
    model_step();
    #1;
    HRESETN = 1'b1; HTRANS = tr; HADDR = a; HBURST = hb; HMASTLOCK = lk;
    SADDRACC = acc; SHREADY = rdy; SHRESP = rsp;
    @(negedge HCLK);
  endtask

  task automatic drive_idle();
    HTRANS = T_IDLE; HADDR = 32'h0; HBURST = B_SINGLE; HMASTLOCK = 1'b0;
    SADDRACC = NONE; SHREADY = ALL; SHRESP = NONE;
  endtask

  task automatic mid_reset();
    @(posedge HCLK);
    model_step();
    #1;
    HRESETN = 1'b0;
    drive_idle();
    model_clear();
    @(negedge HCLK);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation ran past its time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 16; k++) slv_data[k] = 32'hA000_0000 + k;
    slv_data[3] = 32'hDEAD_BEEF;
    HRESETN = 1'b0;
    drive_idle();
    model_clear();
    @(negedge HCLK);
    check("rst_hready", {31'b0, HREADY}, 32'h1);
    check("rst_saddrsel", {16'b0, SADDRSEL}, 32'h0);
    check("rst_hrdata", HRDATA, 32'h0);

    cyc(T_IDLE, 32'h0, B_SINGLE, 0, NONE, ALL, NONE);

    // Single read, same-cycle acceptance by slot 3.
    cyc(T_NSEQ, 32'h3000_0000, B_SINGLE, 0, 16'h0008, ALL, NONE);
    check("t1_sel", {16'b0, SADDRSEL}, 32'h0008);
    cyc(T_IDLE, 32'h0, B_SINGLE, 0, NONE, ALL, NONE);
    check("t1_rdata", HRDATA, 32'hDEAD_BEEF);
    check("t1_ready", {31'b0, HREADY}, 32'h1);
    check("t1_sel_off", {16'b0, SADDRSEL}, 32'h0);

    // Slot 5 accepts after three cycles of waiting.
    for (int i = 0; i < 3; i++) begin
      cyc(T_NSEQ, 32'h5000_0000, B_SINGLE, 0, NONE, ALL, NONE);
      check("t2_wait_sel", {16'b0, SADDRSEL}, 32'h0020);
      check("t2_wait_ready", {31'b0, HREADY}, 32'h0);
    end
    cyc(T_NSEQ, 32'h5000_0000, B_SINGLE, 0, 16'h0020, ALL, NONE);
    check("t2_acc_ready", {31'b0, HREADY}, 32'h1);
    cyc(T_IDLE, 32'h0, B_SINGLE, 0, NONE, ALL, NONE);
    check("t2_rdata", HRDATA, 32'hA000_0005);

    // Slot 7 address taken while slot 2 data phase stalls two cycles.
    cyc(T_NSEQ, 32'h2000_0000, B_SINGLE, 0, 16'h0004, ALL, NONE);
    cyc(T_NSEQ, 32'h7000_0000, B_SINGLE, 0, 16'h0080, 16'hFFFB, NONE);
    check("t3_sel7", {16'b0, SADDRSEL}, 32'h0080);
    cyc(T_NSEQ, 32'h7000_0000, B_SINGLE, 0, NONE, 16'hFFFB, NONE);
    check("t3_taken_sel", {16'b0, SADDRSEL}, 32'h0);
    check("t3_stall", {31'b0, HREADY}, 32'h0);
    cyc(T_NSEQ, 32'h7000_0000, B_SINGLE, 0, NONE, ALL, NONE);
    check("t3_rdata2", HRDATA, 32'hA000_0002);
    check("t3_done", {31'b0, HREADY}, 32'h1);
    cyc(T_IDLE, 32'h0, B_SINGLE, 0, NONE, ALL, NONE);
    check("t3_rdata7", HRDATA, 32'hA000_0007);

    // Unmapped slot 15: two-cycle ERROR, then back-to-back unmapped.
    cyc(T_NSEQ, 32'hF000_0000, B_SINGLE, 0, NONE, ALL, NONE);
    check("t4_sel", {16'b0, SADDRSEL}, 32'h0);
    cyc(T_IDLE, 32'h0, B_SINGLE, 0, NONE, ALL, NONE);
    check("t4_err1", {30'b0, HREADY, HRESP}, 32'h1);
    cyc(T_IDLE, 32'h0, B_SINGLE, 0, NONE, ALL, NONE);
    check("t4_err2", {30'b0, HREADY, HRESP}, 32'h3);
    cyc(T_NSEQ, 32'hF000_0010, B_SINGLE, 0, NONE, ALL, NONE);
    cyc(T_NSEQ, 32'hF000_0020, B_SINGLE, 0, NONE, ALL, NONE);
    check("t4_b2b_err1", {30'b0, HREADY, HRESP}, 32'h1);
    cyc(T_NSEQ, 32'hF000_0020, B_SINGLE, 0, NONE, ALL, NONE);
    check("t4_b2b_err2", {30'b0, HREADY, HRESP}, 32'h3);
    cyc(T_IDLE, 32'h0, B_SINGLE, 0, NONE, ALL, NONE);
    check("t4_b2b_again", {30'b0, HREADY, HRESP}, 32'h1);
    cyc(T_IDLE, 32'h0, B_SINGLE, 0, NONE, ALL, NONE);
    cyc(T_IDLE, 32'h0, B_SINGLE, 0, NONE, ALL, NONE);
    check("t4_clear", {30'b0, HREADY, HRESP}, 32'h2);

    // Slave ERROR mid-burst; master cancels with IDLE.
    cyc(T_NSEQ, 32'h4000_0000, B_INCR4, 0, 16'h0010, ALL, NONE);
    check("te_burst_on", {31'b0, GATEDBURSTXFER}, 32'h1);
    cyc(T_SEQ, 32'h4000_0004, B_INCR4, 0, NONE, 16'hFFEF, 16'h0010);
    check("te_err1", {30'b0, HREADY, HRESP}, 32'h1);
    cyc(T_IDLE, 32'h0, B_SINGLE, 0, NONE, ALL, 16'h0010);
    check("te_err2", {30'b0, HREADY, HRESP}, 32'h3);
    check("te_burst_off", {31'b0, GATEDBURSTXFER}, 32'h0);
    cyc(T_IDLE, 32'h0, B_SINGLE, 0, NONE, ALL, NONE);

    // Locked INCR4 to slot 1.
    cyc(T_NSEQ, 32'h1000_0000, B_INCR4, 1, 16'h0002, ALL, NONE);
    check("t5_first", {30'b0, GATEDHMASTLOCK, GATEDBURSTXFER}, 32'h3);
    for (int i = 1; i < 4; i++) begin
      cyc(T_SEQ, 32'h1000_0000 + 32'(i * 4), B_INCR4, 1, 16'h0002, ALL, NONE);
      check("t5_seq", {30'b0, GATEDHMASTLOCK, GATEDBURSTXFER}, 32'h3);
    end
    cyc(T_IDLE, 32'h0, B_SINGLE, 0, NONE, ALL, NONE);
    cyc(T_IDLE, 32'h0, B_SINGLE, 0, NONE, ALL, NONE);
    check("t5_clear", {30'b0, GATEDHMASTLOCK, GATEDBURSTXFER}, 32'h0);

    // Reset while an address is held in the taken state.
    cyc(T_NSEQ, 32'h2000_0000, B_INCR4, 1, 16'h0004, ALL, NONE);
    cyc(T_NSEQ, 32'h6000_0000, B_INCR4, 1, 16'h0040, 16'hFFFB, NONE);
    check("t6_sel6", {16'b0, SADDRSEL}, 32'h0040);
    cyc(T_NSEQ, 32'h6000_0000, B_INCR4, 1, NONE, 16'hFFFB, NONE);
    check("t6_taken", {16'b0, SADDRSEL}, 32'h0);
    mid_reset();
    check("t6_rst_ready", {31'b0, HREADY}, 32'h1);
    check("t6_rst_sel", {16'b0, SADDRSEL}, 32'h0);
    check("t6_rst_gated", {30'b0, GATEDHMASTLOCK, GATEDBURSTXFER}, 32'h0);
    cyc(T_IDLE, 32'h0, B_SINGLE, 0, NONE, ALL, NONE);
    check("t6_dropped", HRDATA, 32'h0);

`ifdef MASTER_STAGE_REMAP_EN
    #1 REMAP = 1'b1;
    cyc(T_NSEQ, 32'h0000_0000, B_SINGLE, 0, 16'h0002, ALL, NONE);
    check("t7_remap_sel", {16'b0, SADDRSEL}, 32'h0002);
    cyc(T_IDLE, 32'h0, B_SINGLE, 0, NONE, ALL, NONE);
    check("t7_remap_data", HRDATA, 32'hA000_0001);
    #1 REMAP = 1'b0;
`endif

    cyc(T_IDLE, 32'h0, B_SINGLE, 0, NONE, ALL, NONE);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
